// File: rtl/clk_divider.sv
// -----------------------------------------------------------------------------
// clk_divider
//
// Programmable clock generator for the processor test controller. It derives
// clk_o from the system clock either as a continuous divided clock (free-run)
// or as a burst of exactly `rem` output pulses (step mode). The controller
// uses it to run, stop, or single/multi-step the core under test.
//
// Parameters
//   COUNTER_BITS  width of `divider` and the division counter
//   PULSE_BITS    width of `pulse` and the burst counter
//
// Ports
//   clk          in   system clock; all state is clocked by it
//   reset        in   asynchronous, active-low reset
//   option       in   0 = free-run, 1 = step/burst
//   write_pulse  in   single-cycle strobe; loads `pulse` into the burst counter
//   out_enable   in   1 = output allowed, 0 = clk_o held low
//   divider      in   half-period in clk cycles; 0 = pass-through
//   pulse        in   burst length in output pulses
//   clk_o        out  generated clock
// -----------------------------------------------------------------------------
module clk_divider #(
    parameter int COUNTER_BITS = 32,
    parameter int PULSE_BITS   = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    option,
    input  logic                    write_pulse,
    input  logic                    out_enable,
    input  logic [COUNTER_BITS-1:0] divider,
    input  logic [PULSE_BITS-1:0]   pulse,
    output logic                    clk_o
);

    logic [COUNTER_BITS-1:0] cnt;
    logic                    div_q;
    logic                    clk_div_q;
    logic [PULSE_BITS-1:0]   rem;
    logic                    g;

    logic pass_thru;
    logic wrap;
    logic div_rise;
    logic emit_ok;
    logic step_dec;

    assign pass_thru = (divider == '0);

    // A >= compare (not ==) lets a reduced divider take effect at the next
    // edge instead of waiting for the counter to wrap around.
    assign wrap     = (cnt >= (divider - COUNTER_BITS'(1)));
    assign div_rise = !pass_thru && wrap && !div_q;

    // Whether the next base-clock high phase may reach the output.
    assign emit_ok  = out_enable && (!option || (rem != '0));

    // One decrement per emitted pulse in step mode. In pass-through the gate
    // g already captured out_enable at the previous falling edge, so it
    // decides whether the high phase starting now is emitted.
    assign step_dec = option && (rem != '0) &&
                      (pass_thru ? g : (div_rise && out_enable));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            div_q     <= 1'b0;
            clk_div_q <= 1'b0;
            rem       <= '0;
        end else begin
            if (pass_thru) begin
                cnt       <= '0;
                div_q     <= 1'b0;
                clk_div_q <= 1'b0;
            end else if (wrap) begin
                cnt       <= '0;
                div_q     <= ~div_q;
                // High phases start only on a div_q 0->1 transition and always
                // end on the 1->0 transition, so a pulse is never truncated.
                clk_div_q <= div_q ? 1'b0 : emit_ok;
            end else begin
                cnt <= cnt + COUNTER_BITS'(1);
            end

            // A load wins over a same-edge decrement.
            if (write_pulse) begin
                rem <= pulse;
            end else if (step_dec) begin
                rem <= rem - PULSE_BITS'(1);
            end
        end
    end

    // Pass-through gate changes only while clk is low, so clk & g has no runts.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            g <= 1'b0;
        end else begin
            g <= emit_ok;
        end
    end

    assign clk_o = pass_thru ? (clk & g) : clk_div_q;

endmodule

// File: tb/tb_clk_divider.sv
module tb_clk_divider;

    logic        clk;
    logic        reset;
    logic        option;
    logic        write_pulse;
    logic        out_enable;
    logic [31:0] divider;
    logic [31:0] pulse;
    logic        clk_o;

    int n_total = 0;
    int n_pass  = 0;
    int pcnt    = 0;

    clk_divider #(.COUNTER_BITS(32), .PULSE_BITS(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .option      (option),
        .write_pulse (write_pulse),
        .out_enable  (out_enable),
        .divider     (divider),
        .pulse       (pulse),
        .clk_o       (clk_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Every rising edge of clk_o is one output pulse (glitches count too).
    always @(posedge clk_o) pcnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else
            n_pass++;
    endtask

    // Poll clk_o shortly after each rising clk edge until it equals v.
    task automatic wait_level(input logic v, output int c);
        bit ok;
        ok = 1'b0;
        c  = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (clk_o == v) begin
                ok = 1'b1;
                c  = i;
                break;
            end
        end
        chk("wait_level_in_budget", 32'(ok), 32'd1);
    endtask

    // Strobe write_pulse for one clk rise; returns just after that rise.
    task automatic strobe(input logic [31:0] n);
        @(negedge clk);
        #1;
        pulse       = n;
        write_pulse = 1'b1;
        @(posedge clk);
        #1;
        write_pulse = 1'b0;
    endtask

    int base;
    int c0, c1, c2, c3;

    initial begin
        reset       = 1'b0;
        option      = 1'b0;
        write_pulse = 1'b0;
        out_enable  = 1'b1;
        divider     = 32'd0;
        pulse       = 32'd0;

        // Reset state: output low even while clk is high.
        repeat (2) @(posedge clk);
        #2 chk("reset_clk_o", 32'(clk_o), 32'd0);
        chk("reset_rem", dut.rem, 32'd0);
        @(negedge clk);
        #1 reset = 1'b1;

        // Free-run pass-through: clk_o mirrors clk after the first falling edge.
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #2 chk("passthru_high", 32'(clk_o), 32'd1);
            @(negedge clk);
            #2 chk("passthru_low", 32'(clk_o), 32'd0);
        end

        // Free-run divided by 3: high 3, period 6.
        divider = 32'd3;
        wait_level(1'b0, c0);
        wait_level(1'b1, c0);
        wait_level(1'b0, c1);
        wait_level(1'b1, c2);
        chk("div3_high", 32'(c1), 32'd3);
        chk("div3_low", 32'(c2), 32'd3);

        // Reduce to 1: period 2 takes effect promptly.
        divider = 32'd1;
        wait_level(1'b0, c0);
        chk("div1_switch_fast", 32'(c0 <= 4), 32'd1);
        wait_level(1'b1, c0);
        wait_level(1'b0, c1);
        wait_level(1'b1, c2);
        chk("div1_high", 32'(c1), 32'd1);
        chk("div1_low", 32'(c2), 32'd1);

        // Output disable in pass-through: the pulse in flight completes, then
        // nothing for the disabled window, then output resumes.
        divider = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 out_enable = 1'b0;
        @(posedge clk);
        #2 chk("oe_drop_inflight", 32'(clk_o), 32'd1);
        @(negedge clk);
        #1 base = pcnt;
        repeat (14) @(negedge clk);
        #1 chk("oe_low_no_pulses", 32'(pcnt - base), 32'd0);
        out_enable = 1'b1;
        base = pcnt;
        repeat (5) @(posedge clk);
        #2 chk("oe_resume_pulses", 32'(pcnt - base), 32'd4);

        // Step mode without a strobe: nothing.
        option = 1'b1;
        repeat (2) @(posedge clk);
        base = pcnt;
        repeat (10) @(posedge clk);
        #2 chk("step_no_strobe", 32'(pcnt - base), 32'd0);

        // Step mode, 8 pulses starting the cycle after the strobe.
        base = pcnt;
        strobe(32'd8);
        @(posedge clk);
        #2 chk("step8_first_cycle", 32'(clk_o), 32'd1);
        repeat (20) @(posedge clk);
        #2 chk("step8_count", 32'(pcnt - base), 32'd8);
        chk("step8_idle_low", 32'(clk_o), 32'd0);
        chk("step8_rem_zero", dut.rem, 32'd0);

        // Disable after 3 pulses for 10 cycles: pulses deferred, 8 in total.
        base = pcnt;
        strobe(32'd8);
        repeat (3) @(posedge clk);
        #1 out_enable = 1'b0;
        repeat (10) @(posedge clk);
        #2 chk("defer_paused_count", 32'(pcnt - base), 32'd3);
        out_enable = 1'b1;
        repeat (20) @(posedge clk);
        #2 chk("defer_total_count", 32'(pcnt - base), 32'd8);

        // Zero-length burst.
        base = pcnt;
        strobe(32'd0);
        repeat (10) @(posedge clk);
        #2 chk("pulse0_count", 32'(pcnt - base), 32'd0);

        // Reset mid-burst: clk_o drops immediately and the burst is gone.
        strobe(32'd8);
        repeat (2) @(posedge clk);
        #2 chk("midburst_high", 32'(clk_o), 32'd1);
        reset = 1'b0;
        #1 chk("midburst_reset_clk_o", 32'(clk_o), 32'd0);
        chk("midburst_reset_rem", dut.rem, 32'd0);
        @(negedge clk);
        #1 reset = 1'b1;
        divider = 32'd2;
        repeat (4) @(posedge clk);
        #2 chk("post_reset_idle", 32'(clk_o), 32'd0);

        // Divided step: 2 pulses, 2 high / 2 low each.
        base = pcnt;
        strobe(32'd2);
        wait_level(1'b1, c0);
        wait_level(1'b0, c1);
        wait_level(1'b1, c2);
        wait_level(1'b0, c3);
        chk("div2_step_high1", 32'(c1), 32'd2);
        chk("div2_step_low", 32'(c2), 32'd2);
        chk("div2_step_high2", 32'(c3), 32'd2);
        repeat (20) @(posedge clk);
        #2 chk("div2_step_count", 32'(pcnt - base), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
